// File: rtl/dmem_lsu_ctrl.sv
// Load/store sequencer between the RV32I execute stage and a 512x128 data memory.
// Line-crossing accesses take two memory cycles; load data is merged, aligned and extended.
module dmem_lsu_ctrl #(
  parameter int LINE_W    = 128,
  parameter int DEPTH_BIT = 9,
  parameter int ADDR_W    = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [ADDR_W-1:0]    req_addr,
  input  logic                 req_we,
  input  logic [2:0]           req_funct3,
  input  logic [31:0]          req_wdata,
  output logic                 resp_valid,
  output logic [31:0]          resp_rdata,
  output logic                 resp_err,
  output logic [DEPTH_BIT-1:0] mem_addr,
  output logic                 mem_ren,
  output logic [LINE_W-1:0]    mem_wen,
  output logic [LINE_W-1:0]    mem_wr_data,
  input  logic [LINE_W-1:0]    mem_rd_data
);

  localparam int NB    = LINE_W / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int BA_W  = OFF_W + DEPTH_BIT;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ACC0  = 3'd1,
    S_ACC1  = 3'd2,
    S_LWAIT = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  state_t              state_r;
  logic [ADDR_W-1:0]   addr_r;
  logic                we_r;
  logic [2:0]          funct3_r;
  logic [31:0]         wdata_r;
  logic [LINE_W-1:0]   line0_r;

  logic [ADDR_W-1:0]      src_addr_s;
  logic                   src_we_s;
  logic [2:0]             src_f3_s;
  logic [31:0]            src_wdata_s;
  logic [2:0]             size_s;
  logic [3:0]             size_mask_s;
  logic [OFF_W-1:0]       off_s;
  logic [DEPTH_BIT-1:0]   line_s;
  logic                   range_err_s;
  logic                   f3_err_s;
  logic                   err_s;
  logic                   cross_s;
  logic [2*NB-1:0]        byte_mask_s;
  logic [2*LINE_W-1:0]    wr_shift_s;
  logic [2*LINE_W-1:0]    rd_cat_s;
  logic [31:0]            rd_word_s;

  function automatic logic [LINE_W-1:0] expand_mask(input logic [NB-1:0] bytes);
    logic [LINE_W-1:0] bits;
    bits = {LINE_W{1'b0}};
    for (int k = 0; k < NB; k++) begin
      bits[8*k +: 8] = {8{bytes[k]}};
    end
    return bits;
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [31:0] w);
    logic [31:0] r;
    case (f3)
      3'd0:    r = {{24{w[7]}}, w[7:0]};
      3'd1:    r = {{16{w[15]}}, w[15:0]};
      3'd2:    r = w;
      3'd4:    r = {24'd0, w[7:0]};
      3'd5:    r = {16'd0, w[15:0]};
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  assign req_ready = rst_n && (state_r == S_IDLE);

  // In IDLE decode the live request; afterwards decode the captured one.
  always_comb begin
    if (state_r == S_IDLE) begin
      src_addr_s  = req_addr;
      src_we_s    = req_we;
      src_f3_s    = req_funct3;
      src_wdata_s = req_wdata;
    end else begin
      src_addr_s  = addr_r;
      src_we_s    = we_r;
      src_f3_s    = funct3_r;
      src_wdata_s = wdata_r;
    end
  end

  // Access size and its byte-enable pattern
  always_comb begin
    case (src_f3_s[1:0])
      2'd0: begin
        size_s      = 3'd1;
        size_mask_s = 4'b0001;
      end
      2'd1: begin
        size_s      = 3'd2;
        size_mask_s = 4'b0011;
      end
      default: begin
        size_s      = 3'd4;
        size_mask_s = 4'b1111;
      end
    endcase
  end

  assign off_s       = src_addr_s[OFF_W-1:0];
  assign line_s      = src_addr_s[BA_W-1:OFF_W];
  // Past-the-end byte beyond memory size means the access runs off the top.
  assign range_err_s = (src_addr_s[ADDR_W-1:BA_W] != {(ADDR_W-BA_W){1'b0}}) ||
                       (({1'b0, src_addr_s[BA_W-1:0]} + (BA_W+1)'(size_s)) > (BA_W+1)'(NB << DEPTH_BIT));
  assign f3_err_s    = src_we_s ? (src_f3_s > 3'd2) : ((src_f3_s == 3'd3) || (src_f3_s[2:1] == 2'b11));
  assign err_s       = range_err_s || f3_err_s;
  assign cross_s     = ({1'b0, off_s} + (OFF_W+1)'(size_s)) > (OFF_W+1)'(NB);
  assign byte_mask_s = (2*NB)'(size_mask_s) << off_s;
  assign wr_shift_s  = (2*LINE_W)'(src_wdata_s) << {off_s, 3'b000};
  assign rd_cat_s    = cross_s ? {mem_rd_data, line0_r} : {{LINE_W{1'b0}}, mem_rd_data};
  assign rd_word_s   = 32'(rd_cat_s >> {off_s, 3'b000});

  // Sequencer: request capture, memory command generation and response
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= S_IDLE;
      addr_r      <= {ADDR_W{1'b0}};
      we_r        <= 1'b0;
      funct3_r    <= 3'd0;
      wdata_r     <= 32'd0;
      line0_r     <= {LINE_W{1'b0}};
      resp_valid  <= 1'b0;
      resp_rdata  <= 32'd0;
      resp_err    <= 1'b0;
      mem_addr    <= {DEPTH_BIT{1'b0}};
      mem_ren     <= 1'b0;
      mem_wen     <= {LINE_W{1'b0}};
      mem_wr_data <= {LINE_W{1'b0}};
    end else begin
      resp_valid  <= 1'b0;
      resp_rdata  <= 32'd0;
      resp_err    <= 1'b0;
      mem_addr    <= {DEPTH_BIT{1'b0}};
      mem_ren     <= 1'b0;
      mem_wen     <= {LINE_W{1'b0}};
      mem_wr_data <= {LINE_W{1'b0}};
      case (state_r)
        S_IDLE: begin
          if (req_valid) begin
            addr_r   <= req_addr;
            we_r     <= req_we;
            funct3_r <= req_funct3;
            wdata_r  <= req_wdata;
            if (err_s) begin
              state_r    <= S_RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
            end else begin
              state_r  <= S_ACC0;
              mem_addr <= line_s;
              if (req_we) begin
                mem_wen     <= expand_mask(byte_mask_s[NB-1:0]);
                mem_wr_data <= wr_shift_s[LINE_W-1:0];
              end else begin
                mem_ren <= 1'b1;
              end
            end
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_ACC0: begin
          if (cross_s) begin
            state_r  <= S_ACC1;
            mem_addr <= line_s + DEPTH_BIT'(1);
            if (we_r) begin
              mem_wen     <= expand_mask(byte_mask_s[2*NB-1:NB]);
              mem_wr_data <= wr_shift_s[2*LINE_W-1:LINE_W];
            end else begin
              mem_ren <= 1'b1;
            end
          end else if (!we_r) begin
            state_r <= S_LWAIT;
          end else begin
            state_r    <= S_RESP;
            resp_valid <= 1'b1;
          end
        end
        S_ACC1: begin
          if (!we_r) begin
            line0_r <= mem_rd_data;
            state_r <= S_LWAIT;
          end else begin
            state_r    <= S_RESP;
            resp_valid <= 1'b1;
          end
        end
        S_LWAIT: begin
          state_r    <= S_RESP;
          resp_valid <= 1'b1;
          resp_rdata <= load_extend(funct3_r, rd_word_s);
        end
        S_RESP: begin
          state_r <= S_IDLE;
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_lsu_ctrl.sv
// Directed bench for dmem_lsu_ctrl with a 512x128 registered-read memory model.
module tb_dmem_lsu_ctrl;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_valid;
  logic         req_ready;
  logic [31:0]  req_addr;
  logic         req_we;
  logic [2:0]   req_funct3;
  logic [31:0]  req_wdata;
  logic         resp_valid;
  logic [31:0]  resp_rdata;
  logic         resp_err;
  logic [8:0]   mem_addr;
  logic         mem_ren;
  logic [127:0] mem_wen;
  logic [127:0] mem_wr_data;
  logic [127:0] mem_rd_data;

  logic [127:0] mem [512];
  logic         mem_clr;
  int           ren_cnt = 0;
  int           wen_cnt = 0;
  int           checks  = 0;
  int           errors  = 0;
  int           cyc     = 0;
  int           ren0;
  int           wen0;

  always #5 clk = ~clk;

  dmem_lsu_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_we      (req_we),
    .req_funct3  (req_funct3),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_rdata  (resp_rdata),
    .resp_err    (resp_err),
    .mem_addr    (mem_addr),
    .mem_ren     (mem_ren),
    .mem_wen     (mem_wen),
    .mem_wr_data (mem_wr_data),
    .mem_rd_data (mem_rd_data)
  );

  // Memory macro model: bit-masked write, registered read that holds
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 512; i++) mem[i] <= 128'd0;
    end else if (mem_wen != 128'd0) begin
      mem[mem_addr] <= (mem[mem_addr] & ~mem_wen) | (mem_wr_data & mem_wen);
    end
    if (mem_ren) mem_rd_data <= mem[mem_addr];
    if (mem_ren) ren_cnt <= ren_cnt + 1;
    if (mem_wen != 128'd0) wen_cnt <= wen_cnt + 1;
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic issue(input string tag, input logic [31:0] a, input logic we,
                       input logic [2:0] f3, input logic [31:0] wd);
    req_addr   = a;
    req_we     = we;
    req_funct3 = f3;
    req_wdata  = wd;
    req_valid  = 1'b1;
    check({tag, " ready"}, 128'(req_ready), 128'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    cyc = 1;
  endtask

  task automatic wait_resp(input string tag, input int exp_lat, input logic [31:0] exp_rd,
                           input logic exp_err);
    while (resp_valid !== 1'b1 && cyc < 12) tick();
    check({tag, " latency"}, 128'(cyc), 128'(exp_lat));
    check({tag, " rdata"}, 128'(resp_rdata), 128'(exp_rd));
    check({tag, " err"}, 128'(resp_err), 128'(exp_err));
    tick();
    check({tag, " pulse"}, 128'(resp_valid), 128'd0);
  endtask

  initial begin
    rst_n      = 1'b0;
    mem_clr    = 1'b1;
    req_valid  = 1'b0;
    req_addr   = 32'd0;
    req_we     = 1'b0;
    req_funct3 = 3'd0;
    req_wdata  = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst ready", 128'(req_ready), 128'd0);
    check("rst resp_valid", 128'(resp_valid), 128'd0);
    check("rst mem_ren", 128'(mem_ren), 128'd0);
    check("rst mem_wen", mem_wen, 128'd0);
    check("rst mem_addr", 128'(mem_addr), 128'd0);
    rst_n   = 1'b1;
    mem_clr = 1'b0;
    #1;
    check("release ready", 128'(req_ready), 128'd1);

    // Aligned store
    issue("sw10", 32'h0000_0010, 1'b1, 3'd2, 32'hDEAD_BEEF);
    check("sw10 addr", 128'(mem_addr), 128'd1);
    check("sw10 ren", 128'(mem_ren), 128'd0);
    check("sw10 wen", mem_wen, 128'h0000_0000_0000_0000_0000_0000_FFFF_FFFF);
    check("sw10 wdata", mem_wr_data, 128'h0000_0000_0000_0000_0000_0000_DEAD_BEEF);
    wait_resp("sw10", 2, 32'd0, 1'b0);

    // Byte store: only byte 3 enabled, full word shifted onto the data bus
    issue("sb13", 32'h0000_0013, 1'b1, 3'd0, 32'hAABB_CC80);
    check("sb13 wen", mem_wen, 128'h0000_0000_0000_0000_0000_0000_FF00_0000);
    check("sb13 wdata", mem_wr_data, 128'h0000_0000_0000_0000_00AA_BBCC_8000_0000);
    wait_resp("sb13", 2, 32'd0, 1'b0);

    issue("lb13", 32'h0000_0013, 1'b0, 3'd0, 32'd0);
    check("lb13 ren", 128'(mem_ren), 128'd1);
    check("lb13 addr", 128'(mem_addr), 128'd1);
    check("lb13 wen", mem_wen, 128'd0);
    wait_resp("lb13", 3, 32'hFFFF_FF80, 1'b0);
    issue("lbu13", 32'h0000_0013, 1'b0, 3'd4, 32'd0);
    wait_resp("lbu13", 3, 32'h0000_0080, 1'b0);
    issue("lh12", 32'h0000_0012, 1'b0, 3'd1, 32'd0);
    wait_resp("lh12", 3, 32'hFFFF_80AD, 1'b0);
    issue("lhu12", 32'h0000_0012, 1'b0, 3'd5, 32'd0);
    wait_resp("lhu12", 3, 32'h0000_80AD, 1'b0);
    issue("lw10", 32'h0000_0010, 1'b0, 3'd2, 32'd0);
    wait_resp("lw10", 3, 32'h80AD_BEEF, 1'b0);

    // Line-crossing store and loads
    issue("sw1e", 32'h0000_001E, 1'b1, 3'd2, 32'h1122_3344);
    check("sw1e addr0", 128'(mem_addr), 128'd1);
    check("sw1e wen0", mem_wen, 128'hFFFF_0000_0000_0000_0000_0000_0000_0000);
    check("sw1e wdata0", mem_wr_data, 128'h3344_0000_0000_0000_0000_0000_0000_0000);
    tick();
    check("sw1e addr1", 128'(mem_addr), 128'd2);
    check("sw1e wen1", mem_wen, 128'h0000_0000_0000_0000_0000_0000_0000_FFFF);
    check("sw1e wdata1", mem_wr_data, 128'h0000_0000_0000_0000_0000_0000_0000_1122);
    wait_resp("sw1e", 3, 32'd0, 1'b0);
    issue("lw1e", 32'h0000_001E, 1'b0, 3'd2, 32'd0);
    tick();
    check("lw1e addr1", 128'(mem_addr), 128'd2);
    check("lw1e ren1", 128'(mem_ren), 128'd1);
    wait_resp("lw1e", 4, 32'h1122_3344, 1'b0);
    issue("lh1f", 32'h0000_001F, 1'b0, 3'd1, 32'd0);
    wait_resp("lh1f", 4, 32'h0000_2233, 1'b0);
    issue("lbu1f", 32'h0000_001F, 1'b0, 3'd4, 32'd0);
    wait_resp("lbu1f", 3, 32'h0000_0033, 1'b0);

    // Top byte of memory is legal
    issue("sb1fff", 32'h0000_1FFF, 1'b1, 3'd0, 32'h0000_005A);
    check("sb1fff addr", 128'(mem_addr), 128'h1FF);
    check("sb1fff wen", mem_wen, 128'hFF00_0000_0000_0000_0000_0000_0000_0000);
    wait_resp("sb1fff", 2, 32'd0, 1'b0);
    issue("lb1fff", 32'h0000_1FFF, 1'b0, 3'd0, 32'd0);
    wait_resp("lb1fff", 3, 32'h0000_005A, 1'b0);

    // Rejected requests make no memory access
    ren0 = ren_cnt;
    wen0 = wen_cnt;
    issue("lh1fff", 32'h0000_1FFF, 1'b0, 3'd1, 32'd0);
    wait_resp("lh1fff", 1, 32'd0, 1'b1);
    issue("sb2000", 32'h0000_2000, 1'b1, 3'd0, 32'h0000_00FF);
    wait_resp("sb2000", 1, 32'd0, 1'b1);
    issue("ldf3", 32'h0000_0020, 1'b0, 3'd3, 32'd0);
    wait_resp("ldf3", 1, 32'd0, 1'b1);
    issue("stf4", 32'h0000_0020, 1'b1, 3'd4, 32'd0);
    wait_resp("stf4", 1, 32'd0, 1'b1);
    issue("lwhigh", 32'h8000_0010, 1'b0, 3'd2, 32'd0);
    wait_resp("lwhigh", 1, 32'd0, 1'b1);
    check("err no ren", 128'(ren_cnt), 128'(ren0));
    check("err no wen", 128'(wen_cnt), 128'(wen0));

    // Reset during ACC1 of a crossing load
    issue("rstld", 32'h0000_001E, 1'b0, 3'd2, 32'd0);
    tick();
    check("rstld acc1", 128'(mem_ren), 128'd1);
    rst_n = 1'b0;
    tick();
    check("rstld valid", 128'(resp_valid), 128'd0);
    check("rstld rdata", 128'(resp_rdata), 128'd0);
    check("rstld err", 128'(resp_err), 128'd0);
    check("rstld ren", 128'(mem_ren), 128'd0);
    check("rstld wen", mem_wen, 128'd0);
    check("rstld wdata", mem_wr_data, 128'd0);
    check("rstld addr", 128'(mem_addr), 128'd0);
    check("rstld ready", 128'(req_ready), 128'd0);
    tick();
    check("rstld no resp", 128'(resp_valid), 128'd0);
    rst_n = 1'b1;
    #1;
    check("rstld release", 128'(req_ready), 128'd1);
    issue("lwpost", 32'h0000_0010, 1'b0, 3'd2, 32'd0);
    wait_resp("lwpost", 3, 32'h80AD_BEEF, 1'b0);

    // Crossing store cut by reset after ACC0 writes only the first line
    issue("swcut", 32'h0000_002E, 1'b1, 3'd2, 32'hA1B2_C3D4);
    check("swcut wen0", mem_wen, 128'hFFFF_0000_0000_0000_0000_0000_0000_0000);
    check("swcut wdata0", mem_wr_data, 128'hC3D4_0000_0000_0000_0000_0000_0000_0000);
    rst_n = 1'b0;
    tick();
    check("swcut wen1", mem_wen, 128'd0);
    check("swcut valid", 128'(resp_valid), 128'd0);
    rst_n = 1'b1;
    #1;
    issue("lhu2e", 32'h0000_002E, 1'b0, 3'd5, 32'd0);
    wait_resp("lhu2e", 3, 32'h0000_C3D4, 1'b0);
    issue("lhu30", 32'h0000_0030, 1'b0, 3'd5, 32'd0);
    wait_resp("lhu30", 3, 32'h0000_0000, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
